// File: rtl/vend_fsm_param.sv
// vend_fsm_param: parametrised coin vending controller with credit, change and LED bar.
// Optional feature macro: BLINK_REFUND_EN (held, blinking REFUND state).
module vend_fsm_param #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int PRICE       = 5,
    parameter int LED_W       = 8,
    parameter int IDLE_TO_MS  = 5000,
    parameter int DISPENSE_MS = 10000,
    parameter int ANIM_MS     = 500,
    parameter int REFUND_MS   = 2000,
    localparam int CW         = $clog2(PRICE + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_half,
    input  logic             coin_one,
    input  logic             cancel,
    output logic [LED_W-1:0] led,
    output logic             dispense,
    output logic [CW-1:0]    change_units,
    output logic             change_valid,
    output logic             busy
);
    localparam int MS    = CLK_HZ / 1000;
    localparam int TO_C  = IDLE_TO_MS * MS;
    localparam int DSP_C = DISPENSE_MS * MS;
    localparam int ANI_C = ANIM_MS * MS;
    localparam int REF_C = REFUND_MS * MS;
    localparam int TM_A  = (TO_C > DSP_C) ? TO_C : DSP_C;
    localparam int TMAX  = (TM_A > REF_C) ? TM_A : REF_C;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int AW    = $clog2(ANI_C + 1);

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_REFUND} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    credit, credit_n, sum, cu_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic [AW-1:0]    acnt, acnt_n;
    logic [LED_W-1:0] led_n;
    logic [1:0]       add;
    logic             cv_n, anim_step;

    assign add = {coin_one, coin_half};
    assign sum = credit + CW'(add);

    // Thermometer code of the credit, saturating at all-ones.
    function automatic logic [LED_W-1:0] therm(input logic [CW-1:0] v);
        logic [LED_W-1:0] t;
        t = '0;
        for (int i = 0; i < LED_W; i++) t[i] = (i < int'(v));
        return t;
    endfunction

    // Next state, credit, timers and next values of the registered outputs.
    always_comb begin
        state_n   = state;
        credit_n  = credit;
        tmr_n     = tmr + 1'b1;
        acnt_n    = '0;
        led_n     = led;
        cu_n      = change_units;
        cv_n      = 1'b0;
        anim_step = (acnt == AW'(ANI_C - 1));
        case (state)
            S_IDLE, S_CREDIT: begin
                if (add != 2'd0) begin
                    if (sum >= CW'(PRICE)) begin
                        state_n  = S_DISPENSE;
                        cu_n     = sum - CW'(PRICE);
                        cv_n     = 1'b1;
                        credit_n = '0;
                        tmr_n    = '0;
                        led_n    = LED_W'(1);
                    end else begin
                        state_n  = S_CREDIT;
                        credit_n = sum;
                        tmr_n    = '0;
                        led_n    = therm(sum);
                    end
                end else if (state == S_CREDIT && (cancel || tmr == TW'(TO_C - 1))) begin
                    state_n  = S_REFUND;
                    cu_n     = credit;
                    cv_n     = 1'b1;
                    credit_n = '0;
                    tmr_n    = '0;
`ifdef BLINK_REFUND_EN
                    led_n    = '1;
`else
                    led_n    = '0;
`endif
                end else if (state == S_IDLE) begin
                    tmr_n = '0;
                end
            end
            S_DISPENSE: begin
                acnt_n = anim_step ? '0 : acnt + 1'b1;
                led_n  = anim_step ? {led[LED_W-2:0], led[LED_W-1]} : led;
                if (tmr == TW'(DSP_C - 1)) begin
                    state_n = S_IDLE;
                    tmr_n   = '0;
                    led_n   = '0;
                end
            end
            S_REFUND: begin
`ifdef BLINK_REFUND_EN
                acnt_n = anim_step ? '0 : acnt + 1'b1;
                led_n  = anim_step ? ~led : led;
                if (tmr == TW'(REF_C - 1)) begin
                    state_n = S_IDLE;
                    tmr_n   = '0;
                    led_n   = '0;
                end
`else
                state_n = S_IDLE;
                tmr_n   = '0;
                led_n   = '0;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register and registered outputs; reset discards credit without a change strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            credit       <= '0;
            tmr          <= '0;
            acnt         <= '0;
            led          <= '0;
            dispense     <= 1'b0;
            busy         <= 1'b0;
            change_units <= '0;
            change_valid <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            tmr          <= tmr_n;
            acnt         <= acnt_n;
            led          <= led_n;
            dispense     <= (state_n == S_DISPENSE);
            busy         <= (state_n == S_DISPENSE) || (state_n == S_REFUND);
            change_units <= cu_n;
            change_valid <= cv_n;
        end
    end
endmodule

// File: tb/tb_vend_fsm_param.sv
// tb_vend_fsm_param: directed bench with a change scoreboard for vend_fsm_param.
module tb_vend_fsm_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_half = 1'b0;
    logic       coin_one = 1'b0;
    logic       cancel = 1'b0;
    logic [7:0] led;
    logic       dispense;
    logic [2:0] change_units;
    logic       change_valid;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];

    vend_fsm_param #(
        .CLK_HZ(1000), .PRICE(5), .LED_W(8), .IDLE_TO_MS(20),
        .DISPENSE_MS(16), .ANIM_MS(2), .REFUND_MS(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_half(coin_half), .coin_one(coin_one),
        .cancel(cancel), .led(led), .dispense(dispense), .change_units(change_units),
        .change_valid(change_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic h, input logic o, input logic c);
        coin_half = h;
        coin_one  = o;
        cancel    = c;
        @(negedge clk);
        coin_half = 1'b0;
        coin_one  = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    // Every change strobe must match the oldest expected change value.
    always @(negedge clk) begin
        if (rst_n && change_valid) begin
            if (exp_q.size() == 0) check("unexpected_strobe", change_units, 3'bxxx);
            else check("change_units", change_units, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        idle_cycles(3);
        check("rst_led", led, 8'h00);
        check("rst_dispense", dispense, 0);
        check("rst_busy", busy, 0);
        check("rst_cv", change_valid, 0);
        check("rst_cu", change_units, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Five half coins: thermometer then dispense with zero change.
        for (int i = 1; i <= 4; i++) begin
            pulse(1, 0, 0);
            check("half_led", led, (32'd1 << i) - 1);
            idle_cycles(2);
        end
        exp_q.push_back(3'd0);
        pulse(1, 0, 0);
        check("a_dispense", dispense, 1);
        check("a_busy", busy, 1);
        check("a_cv", change_valid, 1);
        check("a_led0", led, 8'h01);
        for (int k = 1; k <= 16; k++) begin
            coin_one = (k == 4);
            @(negedge clk);
            if (k < 16) begin
                check("a_anim", led, 32'd1 << ((k / 2) % 8));
                check("a_disp_hi", dispense, 1);
            end else begin
                check("a_end_led", led, 8'h00);
                check("a_end_disp", dispense, 0);
                check("a_end_busy", busy, 0);
            end
        end
        coin_one = 1'b0;

        // Three one-unit coins: dispense with one half-unit change.
        pulse(0, 1, 0);
        check("b_led1", led, 8'h03);
        idle_cycles(1);
        pulse(0, 1, 0);
        check("b_led2", led, 8'h0F);
        idle_cycles(1);
        exp_q.push_back(3'd1);
        pulse(0, 1, 0);
        check("b_dispense", dispense, 1);
        wait_idle();
        check("b_led_idle", led, 8'h00);

        // Both coins at once, then cancel at credit 3.
        pulse(1, 1, 0);
        check("c_led", led, 8'h07);
        check("c_busy", busy, 0);
        check("c_disp", dispense, 0);
        idle_cycles(2);
        exp_q.push_back(3'd3);
        pulse(0, 0, 1);
        check("c_ref_busy", busy, 1);
        check("c_ref_cv", change_valid, 1);
`ifdef BLINK_REFUND_EN
        check("c_blink0", led, 8'hFF);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k < 6) check("c_blink", led, ((k / 2) % 2 == 0) ? 8'hFF : 8'h00);
            else check("c_ref_end", busy, 0);
        end
`else
        check("c_ref_led", led, 8'h00);
        @(negedge clk);
        check("c_ref_end", busy, 0);
`endif
        wait_idle();

        // One coin then inactivity timeout refunds 2.
        exp_q.push_back(3'd2);
        pulse(0, 1, 0);
        check("d_led", led, 8'h03);
        idle_cycles(19);
        check("d_pre_to", busy, 0);
        @(negedge clk);
        check("d_to_busy", busy, 1);
        check("d_to_cv", change_valid, 1);
        wait_idle();

        // Coin wins over a simultaneous cancel; a later cancel refunds 2.
        pulse(1, 0, 0);
        pulse(1, 0, 1);
        check("e_led", led, 8'h03);
        check("e_busy", busy, 0);
        check("e_cv", change_valid, 0);
        exp_q.push_back(3'd2);
        pulse(0, 0, 1);
        check("e_cv2", change_valid, 1);
        wait_idle();

        // Cancel while idle does nothing.
        pulse(0, 0, 1);
        check("f_cv", change_valid, 0);
        check("f_busy", busy, 0);
        idle_cycles(2);

        // Asynchronous reset in the middle of a dispense.
        pulse(0, 1, 0);
        pulse(0, 1, 0);
        exp_q.push_back(3'd0);
        pulse(1, 0, 0);
        check("g_dispense", dispense, 1);
        idle_cycles(3);
        rst_n = 1'b0;
        #1;
        check("g_led", led, 8'h00);
        check("g_disp", dispense, 0);
        check("g_busy", busy, 0);
        check("g_cv", change_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
        check("g_after_cv", change_valid, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
